// File: rtl/dpi_response_player.sv
// dpi_response_player: buffers DPI-C call results in a small first-word
// fall-through FIFO and replays them on a valid/ready stream. A word that
// carries the done flag ends the session. The block then drains and waits
// in DONE until restart.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | accepting strobes into the FIFO while there is room
// ST_DRAIN | done word buffered; strobes dropped until it is popped
// ST_DONE  | done word consumed, FIFO empty; waits for restart
module dpi_response_player #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_strobe,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_done,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  input  logic                   restart,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   finished
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [DEPTH-1:0]  last_q, last_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic push;
  logic pop;
  logic drop;

  // Head-of-FIFO presentation; payload forced to zero when empty.
  always_comb begin
    out_valid = (level_q != '0);
    out_data  = '0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_data = data_q[rd_ptr_q];
      out_last = last_q[rd_ptr_q];
    end
  end

  // Push/pop/drop decisions. A pop frees a slot the same cycle, so a full
  // FIFO still takes a strobe when the consumer is accepting.
  always_comb begin
    pop  = out_valid && out_ready;
    push = in_strobe && (state_q == ST_RUN) && ((level_q < LW'(DEPTH)) || pop);
    drop = in_strobe && !push;
  end

  // FIFO storage, pointers, occupancy and saturating drop counter.
  always_comb begin
    data_d     = data_q;
    last_d     = last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    if (push) begin
      data_d[wr_ptr_q] = in_result;
      last_d[wr_ptr_q] = in_done;
      wr_ptr_d         = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // Session sequencing: done word accepted -> DRAIN, done word popped -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (push && in_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (restart) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Register update; reset drops any buffered words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      data_q     <= '{default: '0};
      last_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Status outputs straight from registered state.
  always_comb begin
    level    = level_q;
    drop_cnt = drop_cnt_q;
    finished = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_dpi_response_player.sv
// Self-checking bench for dpi_response_player: a table of per-cycle vectors
// followed by hand-written backpressure, mid-stream reset and saturation runs.
module tb_dpi_response_player;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_strobe;
  logic [31:0] in_result;
  logic        in_done;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;
  logic        restart;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;
  logic        finished;

  int n_checks = 0;
  int n_fail   = 0;

  dpi_response_player #(.DATA_W(32), .DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_strobe (in_strobe),
    .in_result (in_result),
    .in_done   (in_done),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .restart   (restart),
    .level     (level),
    .drop_cnt  (drop_cnt),
    .finished  (finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [31:0] res;
    logic        dn;
    logic        rdy;
    logic        rs;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [2:0]  elvl;
    logic [7:0]  edrp;
    logic        ef;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic [31:0] res, logic dn, logic rdy, logic rs,
                              logic ev, logic [31:0] ed, logic el, logic [2:0] elvl,
                              logic [7:0] edrp, logic ef);
    vec_t v;
    v.st = st; v.res = res; v.dn = dn; v.rdy = rdy; v.rs = rs;
    v.ev = ev; v.ed = ed; v.el = el; v.elvl = elvl; v.edrp = edrp; v.ef = ef;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] res, input logic dn,
                       input logic rdy, input logic rs);
    in_strobe = st;
    in_result = res;
    in_done   = dn;
    out_ready = rdy;
    restart   = rs;
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] prev_data;
    logic        prev_stall;
    int          sent;
    int          got;

    drive(0, 0, 0, 0, 0);
    rst = 1'b1;

    // Cycle-by-cycle table: inputs driven this cycle | outputs seen before the edge.
    //                 st  res      dn rdy rs   ev  ed       el lvl drp fin
    // basic replay
    vecs.push_back(mk(1, 32'h11, 0, 1, 0,   0, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h22, 0, 1, 0,   1, 32'h11, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'h33, 0, 1, 0,   1, 32'h22, 0, 1, 0, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'h33, 0, 1, 0, 0));
    // overflow with consumer stalled
    vecs.push_back(mk(1, 32'hA0, 0, 0, 0,   0, 32'h00, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hA1, 0, 0, 0,   1, 32'hA0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 32'hA2, 0, 0, 0,   1, 32'hA0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 32'hA3, 0, 0, 0,   1, 32'hA0, 0, 3, 0, 0));
    vecs.push_back(mk(1, 32'hA4, 0, 0, 0,   1, 32'hA0, 0, 4, 0, 0));
    vecs.push_back(mk(1, 32'hA5, 0, 0, 0,   1, 32'hA0, 0, 4, 1, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hA0, 0, 4, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hA1, 0, 3, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hA2, 0, 2, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hA3, 0, 1, 2, 0));
    // refill, then strobe into a full FIFO while popping
    vecs.push_back(mk(1, 32'hC0, 0, 0, 0,   0, 32'h00, 0, 0, 2, 0));
    vecs.push_back(mk(1, 32'hC1, 0, 0, 0,   1, 32'hC0, 0, 1, 2, 0));
    vecs.push_back(mk(1, 32'hC2, 0, 0, 0,   1, 32'hC0, 0, 2, 2, 0));
    vecs.push_back(mk(1, 32'hC3, 0, 0, 0,   1, 32'hC0, 0, 3, 2, 0));
    vecs.push_back(mk(1, 32'hB0, 0, 1, 0,   1, 32'hC0, 0, 4, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hC1, 0, 4, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hC2, 0, 3, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hC3, 0, 2, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'hB0, 0, 1, 2, 0));
    // termination, drops in DRAIN/DONE, restart
    vecs.push_back(mk(1, 32'h01, 0, 0, 0,   0, 32'h00, 0, 0, 2, 0));
    vecs.push_back(mk(1, 32'h02, 1, 0, 0,   1, 32'h01, 0, 1, 2, 0));
    vecs.push_back(mk(1, 32'h03, 0, 0, 0,   1, 32'h01, 0, 2, 2, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'h01, 0, 2, 3, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'h02, 1, 1, 3, 0));
    vecs.push_back(mk(1, 32'h04, 0, 0, 0,   0, 32'h00, 0, 0, 3, 1));
    vecs.push_back(mk(1, 32'h05, 0, 0, 1,   0, 32'h00, 0, 0, 4, 1));
    vecs.push_back(mk(1, 32'h06, 0, 0, 0,   0, 32'h00, 0, 0, 5, 0));
    vecs.push_back(mk(0, 32'h00, 0, 1, 0,   1, 32'h06, 0, 1, 5, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 1,   0, 32'h00, 0, 0, 5, 0));
    vecs.push_back(mk(0, 32'h00, 0, 0, 0,   0, 32'h00, 0, 0, 5, 0));

    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_data", i), out_data, vecs[i].ed);
      check($sformatf("v%0d_last", i), {31'd0, out_last}, {31'd0, vecs[i].el});
      check($sformatf("v%0d_level", i), {29'd0, level}, {29'd0, vecs[i].elvl});
      check($sformatf("v%0d_drop", i), {24'd0, drop_cnt}, {24'd0, vecs[i].edrp});
      check($sformatf("v%0d_fin", i), {31'd0, finished}, {31'd0, vecs[i].ef});
      drive(vecs[i].st, vecs[i].res, vecs[i].dn, vecs[i].rdy, vecs[i].rs);
    end

    // Backpressure: one strobe per cycle for 8 words, ready toggles each cycle.
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hF0 + k);
    sent = 0;
    got = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        check("bp_hold_data", out_data, prev_data);
      end
      drive(sent < 8, (sent < 8) ? exp_q[sent] : 32'h0, 0, c[0], 0);
      if (sent < 8) sent++;
      if (out_valid && out_ready) begin
        check("bp_order", out_data, exp_q[got]);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    check("bp_count", got, 32'd8);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("bp_no_drop", {24'd0, drop_cnt}, 32'd5);
    check("bp_empty", {29'd0, level}, 32'd0);

    // Reset while three words sit in DRAIN.
    drive(1, 32'hE1, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'hE2, 0, 0, 0);
    @(negedge clk);
    drive(1, 32'hE3, 1, 0, 0);
    @(negedge clk);
    drive(1, 32'hE4, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("mr_level3", {29'd0, level}, 32'd3);
    check("mr_drop_drain", {24'd0, drop_cnt}, 32'd6);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", {31'd0, out_valid}, 32'd0);
    check("mr_data", out_data, 32'd0);
    check("mr_level", {29'd0, level}, 32'd0);
    check("mr_drop", {24'd0, drop_cnt}, 32'd0);
    check("mr_fin", {31'd0, finished}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 32'h55, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    check("mr_post_valid", {31'd0, out_valid}, 32'd1);
    check("mr_post_data", out_data, 32'h55);
    check("mr_post_level", {29'd0, level}, 32'd1);

    // Drop counter saturation: 3 more accepted, 297 dropped.
    for (int k = 0; k < 300; k++) begin
      drive(1, 32'h100 + k, 0, 0, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    check("sat_drop", {24'd0, drop_cnt}, 32'd255);
    check("sat_level", {29'd0, level}, 32'd4);
    check("sat_head", out_data, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no summary expected summary");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dpi_response_player.md
Name: dpi_response_player

Overview:
- Receives result words returned by a DPI-C call: the call site strobes the block once per call with the call's output arguments.
- Buffers those words in a small FIFO and replays them into the design on a valid/ready stream.
- Carries the returned values from the C side back into RTL, with a done-flag termination protocol.
- Sits in the simulation top next to the procedural block that issues the DPI call.

Parameters:
- DATA_W, 32, width of the DPI result word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- in_strobe  input  1  one-cycle pulse: DPI call returned, in_result/in_done valid.
- in_result  input  DATA_W  DPI output argument out_result.
- in_done  input  1  DPI output argument out_done; marks the final word.
- out_valid  output  1  head word available.
- out_data  output  DATA_W  head word payload.
- out_last  output  1  done flag of head word.
- out_ready  input  1  consumer accepts head word.
- restart  input  1  one-cycle pulse: leave DONE, return to RUN.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  CNT_W  strobes discarded; saturating.
- finished  output  1  high in DONE state.

Behaviour:
- Reset (async assert, sync release): FIFO empty, state RUN.
  - out_valid=0, out_data=0, out_last=0, level=0, drop_cnt=0, finished=0.
  - Reset mid-stream discards all buffered words.
- FIFO:
  - First-word fall-through. out_data/out_last show the head entry whenever out_valid=1.
  - out_data=0 and out_last=0 when empty.
  - Pop occurs when out_valid && out_ready.
  - Push accepted when in_strobe && state==RUN && (level<DEPTH || pop in same cycle).
  - A word pushed in cycle N is visible on out_valid at cycle N+1 at the earliest; no bypass.
  - Simultaneous push and pop: level unchanged. At full, this is legal and nothing drops.
  - Read/write pointers wrap modulo DEPTH. level distinguishes full from empty.
- Drops: drop_cnt increments by 1, saturating at 2^CNT_W-1, on any strobe that is not accepted:
  - FIFO full with no pop.
  - State DRAIN.
  - State DONE.
- State machine:
  - RUN: normal operation. An accepted push with in_done=1 moves to DRAIN in the next cycle.
  - DRAIN: no pushes accepted. When a pop occurs with out_last=1 → DONE.
  - DONE: finished=1. FIFO is empty by construction.
    - restart=1 → RUN next cycle; drop_cnt is not cleared.
  - restart outside DONE is ignored.
  - Strobe coincident with restart in DONE is dropped and counted.
- out_valid must remain high and out_data/out_last stable while out_ready=0; no word is lost or reordered.
- level reflects registered occupancy after the previous edge.

Test Plan:
- Basic replay: reset, out_ready=1, strobes with results 0x11, 0x22, 0x33 (done=0) on consecutive cycles → out_data 0x11, 0x22, 0x33 on cycles 1–3 after each strobe, out_last=0, level ≤1, drop_cnt=0.
- Overflow:
  - out_ready=0, six strobes 0xA0..0xA5 → level=4, drop_cnt=2.
  - Then out_ready=1 → pops 0xA0..0xA3 in order, level returns to 0.
- Full with concurrent pop: FIFO full, out_ready=1, strobe 0xB0 in the same cycle → accepted, level stays 4, drop_cnt unchanged, 0xB0 emerges after the 3 older words.
- Termination:
  - Strobes 0x1, 0x2(done=1), 0x3 → 0x3 dropped (drop_cnt=1), state DRAIN.
  - 0x2 pops with out_last=1 → finished=1 the next cycle.
  - Further strobes increment drop_cnt.
  - restart → finished=0; next strobe is accepted.
- Backpressure stability: out_ready toggled 0/1 every cycle over 8 words → each word is presented until accepted, out_data is stable while stalled, the output sequence matches the input order exactly.
- Reset mid-operation: level=3 in DRAIN, assert rst asynchronously between edges → outputs clear immediately; after release, state is RUN and a strobe of 0x55 appears on out_data one cycle later.
